// File: rtl/crt_pkg.sv
// ---------------------------------------------------------------------------
// crt_pkg
// Shared definitions for the CRT pixel fetch path.
//   S_FLUSH / S_LOAD / S_FETCH : pixel fetch FSM state encodings
//   BUS_DW                     : framebuffer bus / pixel data width
// ---------------------------------------------------------------------------
package crt_pkg;

   localparam logic [1:0] S_FLUSH = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FETCH = 2'd2;

   localparam int unsigned BUS_DW = 32;

endpackage

// File: rtl/crt_pixfifo.sv
// ---------------------------------------------------------------------------
// crt_pixfifo
// Synchronous pixel FIFO, DEPTH entries of DW bits. The head word is shown
// combinationally on rdata; pop advances it.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : synchronous clear of pointers and count (wins over push/pop)
//   push, wdata  : write one word (ignored while full)
//   pop, rdata   : advance head (ignored while empty), head data
//   full, empty  : status
//   count        : number of stored words, 0..DEPTH
// DEPTH must be a power of 2 (minimum 4) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module crt_pixfifo
   import crt_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned DW    = BUS_DW
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [DW-1:0]              wdata,
   input  logic                       pop,
   output logic [DW-1:0]              rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_DEPTH);
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         // simultaneous push and pop leaves count unchanged
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/crt_pixfetch.sv
// ---------------------------------------------------------------------------
// crt_pixfetch
// Pixel fetch and return path for the CRT controller. Prefetches framebuffer
// words over a request/acknowledge bus into a FIFO and delivers one pixel per
// clock during active video. Underflow is flagged, never stalls timing.
//   clk, reset_n   : clock, asynchronous active-low reset
//   pixaddr        : next line start address from crt (valid while ven=0)
//   ven            : video enable, high = active pixel this cycle
//   breq, baddr    : bus read request and byte address
//   back, bdata    : read acknowledge and same-cycle read data
//   qpixel, qvalid : registered pixel output and "fetched data" flag
//   underrun       : sticky, pixel requested from an empty FIFO
//   underrun_clr   : synchronous clear of underrun (wins over set)
// ---------------------------------------------------------------------------
module crt_pixfetch
   import crt_pkg::*;
#(
   parameter int unsigned        ADDR_SIZE   = 32,
   parameter int unsigned        DEPTH       = 16,
   parameter int unsigned        PIXEL_BYTES = 4,
   parameter logic [BUS_DW-1:0]  BLANK_PIXEL = 32'h00000000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_SIZE-1:0]  pixaddr,
   input  logic                  ven,
   output logic                  breq,
   output logic [ADDR_SIZE-1:0]  baddr,
   input  logic                  back,
   input  logic [BUS_DW-1:0]     bdata,
   output logic [BUS_DW-1:0]     qpixel,
   output logic                  qvalid,
   output logic                  underrun,
   input  logic                  underrun_clr
);

   localparam int unsigned    AW        = $clog2(DEPTH);
   localparam logic [AW:0]    CNT_DEPTH = (AW+1)'(DEPTH);
   localparam logic [ADDR_SIZE-1:0] ADDR_INC = ADDR_SIZE'(PIXEL_BYTES);

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [ADDR_SIZE-1:0] fetch_addr;
   logic                 ven_d;

   logic                 fifo_flush;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic [BUS_DW-1:0]    fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [AW:0]          fifo_count;
   logic                 pix_avail;

   // Request is combinational so it withdraws in the same cycle the FIFO
   // fills or the FSM leaves S_FETCH; an ack can never complete a dropped
   // request.
   assign breq       = (state == S_FETCH) && (fifo_count < CNT_DEPTH);
   assign baddr      = fetch_addr;
   assign fifo_flush = (state == S_FLUSH);
   assign fifo_push  = breq && back && !fifo_full;

   // Contents are being discarded during S_FLUSH, so treat the FIFO as empty.
   assign pix_avail  = !fifo_empty && (state != S_FLUSH);
   assign fifo_pop   = ven && pix_avail;

   crt_pixfifo #(
      .DEPTH (DEPTH),
      .DW    (BUS_DW)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (fifo_flush),
      .push    (fifo_push),
      .wdata   (bdata),
      .pop     (fifo_pop),
      .rdata   (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_FLUSH: state_nxt = S_LOAD;
         S_LOAD:  if (!ven) state_nxt = S_FETCH;
         S_FETCH: if (ven_d && !ven) state_nxt = S_FLUSH;
         default: state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_FLUSH;
         fetch_addr <= '0;
         ven_d      <= 1'b0;
      end else begin
         state <= state_nxt;
         ven_d <= ven;
         if (state == S_LOAD && !ven) begin
            fetch_addr <= pixaddr;
         end else if (fifo_push) begin
            fetch_addr <= fetch_addr + ADDR_INC;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         qpixel   <= BLANK_PIXEL;
         qvalid   <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (fifo_pop) begin
            qpixel <= fifo_rdata;
            qvalid <= 1'b1;
         end else begin
            qpixel <= BLANK_PIXEL;
            qvalid <= 1'b0;
         end
         if (underrun_clr) begin
            underrun <= 1'b0;
         end else if (ven && !pix_avail) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule
